// File: rtl/lm_sm_sequencer_pkg.sv
// Shared definitions for the LM/SM micro-op sequencer: the default opcodes
// and the state encoding.
package lm_sm_sequencer_pkg;

  localparam logic [3:0] LM_OPCODE = 4'b0110;
  localparam logic [3:0] SM_OPCODE = 4'b0111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_e;

endpackage

// File: rtl/lm_sm_sequencer_pri_enc8.sv
// 8-bit lowest-set-bit encoder. It reports the index of the lowest set bit,
// whether any bit is set, and whether exactly one bit is set.
module pri_enc8 (
  input  logic [7:0] in_bits,
  output logic [2:0] idx,
  output logic       valid,
  output logic       one_hot
);

  // Scan from the MSB down so that the lowest set bit is the last one written.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
    idx     = 3'd0;
    valid   = |in_bits;
    one_hot = valid && ((in_bits & (in_bits - 8'd1)) == 8'd0);
    for (int i = 7; i >= 0; i--) begin
      if (in_bits[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Load/store-multiple sequencer. It captures an LM/SM instruction in decode
// and expands its register mask into one micro-op per set bit, lowest
// register first, while stalling fetch.
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
#(
  parameter logic [3:0] OP_LM = LM_OPCODE,
  parameter logic [3:0] OP_SM = SM_OPCODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  input  logic        flush,
  input  logic        uop_ready,
  output logic        uop_valid,
  output logic        uop_is_load,
  output logic [2:0]  uop_base,
  output logic [2:0]  uop_rd,
  output logic [2:0]  uop_offset,
  output logic        uop_last,
  output logic        stall_fetch,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [7:0]  mask_q;
  logic [2:0]  offset_q;
  logic [2:0]  base_q;
  logic        is_load_q;

  logic [3:0]  opcode;
  logic        is_lm, is_sm;
  logic        capture;
  logic        accept;
  logic [2:0]  enc_idx;
  logic        enc_valid;
  logic        enc_one_hot;

  assign opcode  = instr[15:12];
  assign is_lm   = (opcode == OP_LM);
  assign is_sm   = (opcode == OP_SM);
  // A zero mask or a flush in the same cycle means there is nothing to expand.
  assign capture = (state_q == ST_IDLE) && instr_valid && (is_lm || is_sm) &&
                   (instr[7:0] != 8'd0) && !flush;
  assign accept  = (state_q == ST_SEQ) && uop_ready;

  pri_enc8 u_enc (
    .in_bits (mask_q),
    .idx     (enc_idx),
    .valid   (enc_valid),
    .one_hot (enc_one_hot)
  );

  // State register; reset overrides everything, including a running sequence.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: flush wins over acceptance; the last accepted micro-op ends the sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (capture) state_d = ST_SEQ;
      ST_SEQ: begin
        if (flush)                       state_d = ST_IDLE;
        else if (accept && enc_one_hot)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequence context: latched on capture, lowest mask bit retired on each accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q    <= 8'd0;
      offset_q  <= 3'd0;
      base_q    <= 3'd0;
      is_load_q <= 1'b0;
    end else if ((state_q == ST_SEQ) && flush) begin
      mask_q   <= 8'd0;
      offset_q <= 3'd0;
    end else if (capture) begin
      mask_q    <= instr[7:0];
      offset_q  <= 3'd0;
      base_q    <= instr[11:9];
      is_load_q <= is_lm;
    end else if (accept) begin
      // x & (x-1) clears exactly the lowest set bit, the one just issued.
      mask_q   <= mask_q & (mask_q - 8'd1);
      offset_q <= offset_q + 3'd1;
    end
  end

  // Outputs: micro-op fields come straight from registers so they hold while not ready.
  always_comb begin
    uop_valid   = (state_q == ST_SEQ) && enc_valid;
    uop_is_load = is_load_q;
    uop_base    = base_q;
    uop_rd      = enc_idx;
    uop_offset  = offset_q;
    uop_last    = (state_q == ST_SEQ) && enc_one_hot;
    busy        = (state_q == ST_SEQ);
    // Fetch is released in the cycle the final micro-op leaves, so the next
    // instruction lands in decode exactly as the sequencer returns to IDLE.
    if (state_q == ST_SEQ) stall_fetch = !(enc_one_hot && uop_ready);
    else                   stall_fetch = capture;
  end

endmodule

// File: doc/lm_sm_sequencer.md
LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 SHALL use parameter OP_LM, default 4'b0110, as the load-multiple opcode in instr[15:12].
REQ-002 SHALL use parameter OP_SM, default 4'b0111, as the store-multiple opcode in instr[15:12].
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port instr_valid, input, 1, decode-stage instruction present.
REQ-006 SHALL have port instr, input, 16, decode-stage instruction: RA = instr[11:9], mask = instr[7:0].
REQ-007 SHALL have port flush, input, 1, pipeline flush from branch/jump resolution.
REQ-008 SHALL have port uop_ready, input, 1, downstream stage accepts the current micro-op.
REQ-009 SHALL have port uop_valid, output, 1, micro-op present.
REQ-010 SHALL have port uop_is_load, output, 1: 1 for LM, 0 for SM.
REQ-011 SHALL have port uop_base, output, 3, base register RA.
REQ-012 SHALL have port uop_rd, output, 3, register transferred by this micro-op.
REQ-013 SHALL have port uop_offset, output, 3, word offset from base (0..7).
REQ-014 SHALL have port uop_last, output, 1, final micro-op of the sequence.
REQ-015 SHALL have port stall_fetch, output, 1, holds fetch/decode registers.
REQ-016 SHALL have port busy, output, 1, high in state SEQ.

Function
REQ-017 SHALL implement two states, IDLE and SEQ.
REQ-018 In IDLE, when instr_valid is high, the opcode is OP_LM/OP_SM, the mask is nonzero and flush is low, the block SHALL latch mask, RA and type, clear the offset to 0 and enter SEQ on the next edge.
REQ-019 In IDLE, stall_fetch SHALL be combinationally high in the capture cycle of REQ-018, and low otherwise.
REQ-020 An LM/SM instruction with mask 8'h00 SHALL be ignored: no micro-op, no stall, remain in IDLE.
REQ-021 Non-LM/SM instructions SHALL be ignored in every state.
REQ-022 In SEQ, uop_valid SHALL be 1 and uop_rd SHALL be the index of the lowest set bit of the remaining mask (bit i maps to Ri).
REQ-023 On uop_valid && uop_ready, the block SHALL clear that mask bit and increment the offset by 1.
REQ-024 uop_offset SHALL equal the number of micro-ops already accepted in the current sequence.
REQ-025 uop_last SHALL be high exactly when the remaining mask has one bit set.
REQ-026 When the last micro-op is accepted, the block SHALL return to IDLE on the next edge.
REQ-027 In SEQ, stall_fetch SHALL be high, except in the cycle where uop_last && uop_ready.
REQ-028 When uop_ready is low, all uop_* outputs SHALL hold stable.
REQ-029 In SEQ, instr_valid/instr SHALL be ignored.
REQ-030 Flush SHALL take priority over acceptance and capture: the remaining mask is discarded, the block enters IDLE next edge, and no further micro-op is emitted.
REQ-031 A new LM/SM instruction SHALL be capturable in the cycle immediately after a sequence returns to IDLE (no bubble beyond that).
REQ-032 Throughput SHALL be one micro-op per cycle while uop_ready is high; first micro-op appears one cycle after capture.

Reset
REQ-033 On rst high at a clock edge, the block SHALL enter IDLE with mask 0, offset 0, base 0 and type 0.
REQ-034 Reset values SHALL be: uop_valid 0, uop_last 0, stall_fetch 0, busy 0, uop_rd/uop_base/uop_offset 0, uop_is_load 0.
REQ-035 Reset SHALL override flush, capture and acceptance, including mid-sequence.

Structure
REQ-036 A shared package SHALL hold OP_LM/OP_SM constants and the IDLE/SEQ state encoding.
REQ-037 A sub-module pri_enc8 (8-bit lowest-set-bit encoder: 3-bit index, valid, one-hot-remaining flag) SHALL produce uop_rd and uop_last.

Verification
REQ-038 LM R2, mask 8'b1010_0101, uop_ready=1 -> 4 uops with rd=0,2,5,7; offset=0,1,2,3; uop_last on rd=7; stall_fetch high for 4 cycles (capture + 3).
REQ-039 SM, mask 8'h80, uop_ready toggling 0,1 -> a single uop with rd=7, offset=0, uop_last=1, held stable while not ready; is_load=0.
REQ-040 LM with mask 8'hFF, flush asserted on the 3rd uop cycle -> no uop after flush, busy=0 next cycle.
REQ-041 LM with mask 8'h00, then ADD -> no uop, stall_fetch never high.
REQ-042 rst asserted mid-sequence (mask 8'h0F after 2 accepts) -> next cycle all outputs at reset values; back-to-back LM/SM after completion is captured in the first IDLE cycle.
